key_schedule_inv: RTL

Iterative DES decryption key-schedule generator. It accepts a 56-bit post-PC1 key (C0‖D0) and emits the sixteen 48-bit round keys in reverse order, K16 first and K1 last. Keys go out one per accepted beat on a valid/ready stream, produced by circular right rotation of the C and D halves. It sits between key loading and the round datapath when the core runs in decrypt mode, mirroring the forward (left-rotate) schedule.

---
 rtl/des_pkg.sv | 28 ++
 rtl/crr_28bit.sv | 18 +
 rtl/perm_PC2.sv | 13 +
 rtl/key_schedule_inv.sv | 94 +++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: widths, per-round shift amounts, PC2 selection table and
// the key-schedule FSM state type.
package des_pkg;

  localparam int KEY_W  = 56;
  localparam int HALF_W = 28;
  localparam int RK_W   = 48;

  // Rotation amount for forward round n+1 (entry n)
  localparam logic [1:0] DES_SHIFT [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // 1-based source bit positions of C||D (bit 1 = MSB) for each PC2 output, MSB first
  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

endpackage

// File: rtl/crr_28bit.sv
// 28-bit circular right rotate by 1 or 2; the amount comes from the round index via
// DES_SHIFT, undoing the forward schedule's left rotation for that round.
module crr_28bit
  import des_pkg::*;
(
  input  logic [HALF_W-1:0] d,
  input  logic [3:0]        rnd,
  output logic [HALF_W-1:0] q
);

  always_comb begin
    q = {d[0], d[HALF_W-1:1]};
    if (DES_SHIFT[rnd] == 2'd2) begin
      q = {d[1:0], d[HALF_W-1:2]};
    end
  end

endmodule

// File: rtl/perm_PC2.sv
// DES permuted choice 2: selects 48 round-key bits from the 56-bit C||D.
module perm_PC2
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] cd,
  output logic [RK_W-1:0]  k
);

  for (genvar j = 0; j < RK_W; j++) begin : g_bit
    assign k[RK_W-1-j] = cd[KEY_W-PC2_TAB[j]];
  end

endmodule

// File: rtl/key_schedule_inv.sv
// DES decryption key schedule: emits K16..K1 on a valid/ready stream by right-rotating C and D.
// Optional build macro KEY_SCHEDULE_INV_ZEROIZE_EN clears the key state on the final beat.
//
// state | meaning
// IDLE  | no sequence; waiting for start to load x
// RUN   | presenting PC2(r) as round key idx+1; rotate back on each accepted beat
module key_schedule_inv
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  x,
  output logic              busy,
  output logic [RK_W-1:0]   k,
  output logic              k_valid,
  input  logic              k_ready,
  output logic              k_last,
  output logic [3:0]        i
);

  ks_state_t         state;
  logic [KEY_W-1:0]  r;
  logic [3:0]        idx;
  logic [HALF_W-1:0] c_nxt;
  logic [HALF_W-1:0] d_nxt;

  crr_28bit u_crr_c (
    .d   (r[KEY_W-1:HALF_W]),
    .rnd (idx),
    .q   (c_nxt)
  );

  crr_28bit u_crr_d (
    .d   (r[HALF_W-1:0]),
    .rnd (idx),
    .q   (d_nxt)
  );

  perm_PC2 u_pc2 (
    .cd (r),
    .k  (k)
  );

  assign i = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      r       <= '0;
      idx     <= 4'd0;
      busy    <= 1'b0;
      k_valid <= 1'b0;
      k_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r       <= x;
            idx     <= 4'd15;
            state   <= RUN;
            busy    <= 1'b1;
            k_valid <= 1'b1;
            k_last  <= 1'b0;
          end
        end
        RUN: begin
          if (k_ready) begin
            if (idx == 4'd0) begin
              state   <= IDLE;
              busy    <= 1'b0;
              k_valid <= 1'b0;
              k_last  <= 1'b0;
`ifdef KEY_SCHEDULE_INV_ZEROIZE_EN
              r       <= '0;
`endif
            end else begin
              r      <= {c_nxt, d_nxt};
              idx    <= idx - 4'd1;
              k_last <= (idx == 4'd1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          k_valid <= 1'b0;
          k_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
